pipeline_hazard_ctrl: RTL
=========================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage RV64 pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB regs).
//  Detects load-use hazards, converts taken branches resolved in MEM into flushes, and freezes the
//  pipeline while data memory is not ready (with timeout). Drives pc/IF-ID write enables, per-register
//  flush/hold lines, and saturating performance counters.
// PARAMETERS
//  CNT_W        32  width of stall_cycles / flush_events counters (saturating)
//  MEM_TIMEOUT  16  max consecutive MEM_WAIT cycles before entering ERROR; must be >= 1
// PORTS
//  clk            in   1      clock, all state updates on posedge
//  reset          in   1      synchronous, active-high
//  ifid_rs1       in   5      rs1 of instruction in IF/ID
//  ifid_rs2       in   5      rs2 of instruction in IF/ID
//  ifid_uses_rs2  in   1      IF/ID instruction reads rs2 (R/S/B type)
//  idex_memread   in   1      ID/EX Memread
//  idex_rd        in   5      ID/EX rd
//  exmem_branch_taken in 1    branch in EX/MEM resolved taken
//  dmem_req       in   1      MEM-stage load/store active this cycle
//  dmem_ready     in   1      data memory completes access this cycle
//  pc_write       out  1      1 = PC updates
//  ifid_write     out  1      1 = IF/ID captures
//  flush_ifid     out  1      clear IF/ID
//  flush_idex     out  1      clear ID/EX (drives its flush input)
//  flush_exmem    out  1      clear EX/MEM
//  hold_pipe      out  1      ID/EX and EX/MEM keep contents
//  bubble_memwb   out  1      MEM/WB loads a bubble (Regwrite=0)
//  mem_err        out  1      sticky memory timeout error
//  stall_cycles   out  CNT_W  count of stall cycles
//  flush_events   out  CNT_W  count of branch flushes
// BEHAVIOUR
//  State: RUN, MEM_WAIT, ERROR (registered). Control outputs are combinational from state + inputs
//  (same-cycle effect on the pipeline registers); counters and mem_err are registered.
//  Reset: state=RUN, wait_cnt=0, counters=0, mem_err=0. In the reset cycle all control outputs take
//  RUN/no-hazard values: pc_write=1, ifid_write=1, all flush/hold/bubble=0.
//  lu_hazard = idex_memread && idex_rd!=0 && (idex_rd==ifid_rs1 || (ifid_uses_rs2 && idex_rd==ifid_rs2)).
//  mem_stall = dmem_req && !dmem_ready.
//  Priority per cycle, RUN: mem_stall > exmem_branch_taken > lu_hazard > normal.
//   mem_stall: pc_write=0, ifid_write=0, hold_pipe=1, bubble_memwb=1; next=MEM_WAIT, wait_cnt=1.
//   branch:    flush_ifid=flush_idex=flush_exmem=1, pc_write=1, ifid_write=1; flush_events+1.
//   lu_hazard: pc_write=0, ifid_write=0, flush_idex=1 (single bubble); stall_cycles+1.
//   normal:    pc_write=ifid_write=1, all others 0.
//  MEM_WAIT: if dmem_ready -> outputs as RUN evaluated with mem_stall=0 (branch/lu may act this cycle),
//   next=RUN, wait_cnt=0. Else freeze outputs as above, wait_cnt+1; wait_cnt==MEM_TIMEOUT -> ERROR.
//   Branch/lu in EX/MEM, ID/EX are held, so they are acted on at exit; never lost or doubled.
//  ERROR: permanent freeze (pc_write=0, ifid_write=0, hold_pipe=1, bubble_memwb=1), mem_err=1;
//   leave only via reset.
//  stall_cycles increments every cycle with pc_write=0, incl. MEM_WAIT and ERROR; flush_events once
//   per flush cycle. Both saturate at 2^CNT_W-1 (no wrap).
//  hold_pipe and flush_* never both 1 in one cycle. Reset mid-MEM_WAIT returns to RUN immediately.
// TESTING
//  1 lw x5 in ID/EX (idex_memread=1, idex_rd=5), ifid_rs1=5 -> 1 cycle pc_write=0, flush_idex=1; stall_cycles=1.
//  2 idex_rd=0 with memread, ifid_rs1=0 -> no stall; also rs2 match with ifid_uses_rs2=0 -> no stall.
//  3 exmem_branch_taken=1 together with lu_hazard -> only flushes asserted, pc_write=1; flush_events=1.
//  4 dmem_req=1, dmem_ready low 3 cycles -> hold_pipe=1 for 3 cycles, 4th cycle RUN; stall_cycles=3.
//  5 dmem_ready held low MEM_TIMEOUT=16 cycles -> ERROR, mem_err=1 sticky; reset -> RUN, counters 0.
//  6 CNT_W=4, 20 lu stalls -> stall_cycles stays 15; branch taken during MEM_WAIT flushes on exit cycle once.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use interlock, branch
// flush from MEM, data-memory wait freeze with timeout, and saturating
// performance counters. Control outputs are combinational from state + inputs.
module pipeline_hazard_ctrl #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       ifid_rs1,
    input  logic [4:0]       ifid_rs2,
    input  logic             ifid_uses_rs2,
    input  logic             idex_memread,
    input  logic [4:0]       idex_rd,
    input  logic             exmem_branch_taken,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic             flush_exmem,
    output logic             hold_pipe,
    output logic             bubble_memwb,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1, ERROR = 2'd2} state_t;

    // One spare bit so wait_cnt + 1 can never wrap below the limit.
    localparam int WC_W = $clog2(MEM_TIMEOUT + 1) + 1;
    localparam logic [WC_W-1:0] WAIT_LIMIT = WC_W'(MEM_TIMEOUT);

    state_t          state, state_next;
    logic [WC_W-1:0] wait_cnt, wait_next, wait_inc;
    logic            lu_hazard, mem_stall;
    logic            act_freeze, act_branch, act_lu;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign lu_hazard = idex_memread && (idex_rd != 5'd0) &&
                       ((idex_rd == ifid_rs1) || (ifid_uses_rs2 && (idex_rd == ifid_rs2)));
    assign mem_stall = dmem_req && !dmem_ready;
    assign wait_inc  = wait_cnt + 1'b1;

    // State register; reset drops straight back to RUN from any state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_next;
        end
    end

    // Next-state logic: enter MEM_WAIT on a stall, time out into ERROR.
    always_comb begin
        state_next = state;
        wait_next  = wait_cnt;
        case (state)
            RUN: begin
                if (mem_stall) begin
                    state_next = MEM_WAIT;
                    wait_next  = WC_W'(1);
                end
            end
            MEM_WAIT: begin
                if (dmem_ready) begin
                    state_next = RUN;
                    wait_next  = '0;
                end else begin
                    wait_next = wait_inc;
                    if (wait_inc >= WAIT_LIMIT) state_next = ERROR;
                end
            end
            default: state_next = ERROR;
        endcase
    end

    // Output decode: freeze beats branch flush beats load-use bubble.
    always_comb begin
        act_freeze = 1'b0;
        act_branch = 1'b0;
        act_lu     = 1'b0;
        if (!reset) begin
            case (state)
                RUN:      act_freeze = mem_stall;
                MEM_WAIT: act_freeze = !dmem_ready;
                default:  act_freeze = 1'b1;
            endcase
            act_branch = !act_freeze && exmem_branch_taken;
            act_lu     = !act_freeze && !exmem_branch_taken && lu_hazard;
        end
        pc_write     = !(act_freeze || act_lu);
        ifid_write   = !(act_freeze || act_lu);
        hold_pipe    = act_freeze;
        bubble_memwb = act_freeze;
        flush_ifid   = act_branch;
        flush_exmem  = act_branch;
        flush_idex   = act_branch || act_lu;
    end

    // Saturating counters and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= '0;
            flush_events <= '0;
            mem_err      <= 1'b0;
        end else begin
            if (!pc_write) stall_cycles <= sat_inc(stall_cycles);
            if (act_branch) flush_events <= sat_inc(flush_events);
            if (state_next == ERROR) mem_err <= 1'b1;
        end
    end

endmodule
